// File: rtl/scaler_v_linebuf.sv
// Vertical-scaler line buffer: four rotating line banks present the current pixel
// plus the same column from the three preceding lines, all retimed by two clocks.
module scaler_v_linebuf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] do0_o,
  output logic [DATA_WIDTH-1:0] do1_o,
  output logic [DATA_WIDTH-1:0] do2_o,
  output logic [DATA_WIDTH-1:0] do3_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic [1:0]            lines_o,
  output logic                  ovf_o
);

  localparam int LINE_MAX = 1 << ADDR_WIDTH;

  // control state
  logic [1:0]            wr_bank_reg, wr_bank_next;
  logic [ADDR_WIDTH:0]   wr_addr_reg, wr_addr_next;
  logic                  line_has_pix_reg, line_has_pix_next;
  logic [1:0]            line_cnt_reg, line_cnt_next;
  logic                  ovf_reg, ovf_next;
  logic                  synced_reg, synced_next;
  logic                  hs_d_reg, vs_d_reg;

  logic                  hs_rise, vs_rise, accept, line_full, wr_en, ovf_now;
  logic [ADDR_WIDTH-1:0] ram_addr;

  assign hs_rise   = hs_i & ~hs_d_reg;
  assign vs_rise   = vs_i & ~vs_d_reg;
  assign accept    = de_i & ~hs_i & ~vs_i;
  assign line_full = wr_addr_reg[ADDR_WIDTH];
  assign wr_en     = accept & ~line_full;
  assign ovf_now   = ovf_reg | (accept & line_full);
  assign ram_addr  = wr_addr_reg[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_reg      <= '0;
      wr_addr_reg      <= '0;
      line_has_pix_reg <= 1'b0;
      line_cnt_reg     <= '0;
      ovf_reg          <= 1'b0;
      synced_reg       <= 1'b0;
      hs_d_reg         <= 1'b0;
      vs_d_reg         <= 1'b0;
    end else begin
      wr_bank_reg      <= wr_bank_next;
      wr_addr_reg      <= wr_addr_next;
      line_has_pix_reg <= line_has_pix_next;
      line_cnt_reg     <= line_cnt_next;
      ovf_reg          <= ovf_next;
      synced_reg       <= synced_next;
      hs_d_reg         <= hs_i;
      vs_d_reg         <= vs_i;
    end
  end

  // Frame start wins over line advance; line count only grows once a frame
  // start has been seen since reset, so a mid-frame release reports no history.
  always_comb begin
    wr_bank_next      = wr_bank_reg;
    wr_addr_next      = wr_addr_reg;
    line_has_pix_next = line_has_pix_reg;
    line_cnt_next     = line_cnt_reg;
    ovf_next          = ovf_reg;
    synced_next       = synced_reg;
    if (vs_rise) begin
      wr_bank_next      = '0;
      wr_addr_next      = '0;
      line_cnt_next     = '0;
      line_has_pix_next = 1'b0;
      ovf_next          = 1'b0;
      synced_next       = 1'b1;
    end else if (hs_rise) begin
      wr_addr_next      = '0;
      line_has_pix_next = 1'b0;
      if (line_has_pix_reg) begin
        wr_bank_next = wr_bank_reg + 2'd1;
        if (synced_reg && line_cnt_reg != 2'd3)
          line_cnt_next = line_cnt_reg + 2'd1;
      end
    end else if (accept) begin
      if (line_full) begin
        ovf_next = 1'b1;
      end else begin
        wr_addr_next      = wr_addr_reg + {{ADDR_WIDTH{1'b0}}, 1'b1};
        line_has_pix_next = 1'b1;
      end
    end
  end

  // line banks; the bank being written is never read in the same cycle
  logic [DATA_WIDTH-1:0] bank_q [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      localparam logic [1:0] BANK_ID = 2'(gi);
      logic [DATA_WIDTH-1:0] mem [LINE_MAX];
      logic [DATA_WIDTH-1:0] rd_data_reg;
      logic                  we, re;

      assign we = wr_en & (wr_bank_reg == BANK_ID);
      assign re = wr_en & (wr_bank_reg != BANK_ID);

      always_ff @(posedge clk) begin
        if (we)
          mem[ram_addr] <= di_i;
      end

      always_ff @(posedge clk) begin
        if (re)
          rd_data_reg <= mem[ram_addr];
      end

      assign bank_q[gi] = rd_data_reg;
    end
  endgenerate

  // stage 1: controls travelling alongside the RAM read
  logic                  de_d1_reg, hs_d1_reg, vs_d1_reg, ovf_d1_reg;
  logic [DATA_WIDTH-1:0] di_d1_reg;
  logic [1:0]            lines_d1_reg, bank_d1_reg;
  logic [3:1]            tap_en_d1_reg;
  logic [3:1]            tap_en;

  generate
    for (gi = 1; gi <= 3; gi++) begin : g_tap_en
      assign tap_en[gi] = wr_en & (line_cnt_reg >= 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_d1_reg     <= 1'b0;
      hs_d1_reg     <= 1'b0;
      vs_d1_reg     <= 1'b0;
      ovf_d1_reg    <= 1'b0;
      di_d1_reg     <= '0;
      lines_d1_reg  <= '0;
      bank_d1_reg   <= '0;
      tap_en_d1_reg <= '0;
    end else begin
      de_d1_reg     <= accept;
      hs_d1_reg     <= hs_i;
      vs_d1_reg     <= vs_i;
      ovf_d1_reg    <= ovf_now;
      di_d1_reg     <= di_i;
      lines_d1_reg  <= line_cnt_reg;
      bank_d1_reg   <= wr_bank_reg;
      tap_en_d1_reg <= tap_en;
    end
  end

  // stage 2: output registers; history taps hold between valid pixels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      do0_o   <= '0;
      de_o    <= 1'b0;
      hs_o    <= 1'b0;
      vs_o    <= 1'b0;
      lines_o <= '0;
      ovf_o   <= 1'b0;
    end else begin
      do0_o   <= di_d1_reg;
      de_o    <= de_d1_reg;
      hs_o    <= hs_d1_reg;
      vs_o    <= vs_d1_reg;
      lines_o <= lines_d1_reg;
      ovf_o   <= ovf_d1_reg;
    end
  end

  generate
    for (gi = 1; gi <= 3; gi++) begin : g_tap
      localparam logic [1:0] TAP_K = 2'(gi);
      logic [DATA_WIDTH-1:0] tap_reg;
      logic [1:0]            src_bank;

      assign src_bank = bank_d1_reg - TAP_K;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          tap_reg <= '0;
        else if (de_d1_reg)
          tap_reg <= tap_en_d1_reg[gi] ? bank_q[src_bank] : '0;
      end
    end
  endgenerate

  assign do1_o = g_tap[1].tap_reg;
  assign do2_o = g_tap[2].tap_reg;
  assign do3_o = g_tap[3].tap_reg;

endmodule

// File: tb/tb_scaler_v_linebuf.sv
// Scoreboard bench for scaler_v_linebuf: a behavioural line-history model pushes
// expected taps per accepted pixel; a monitor pops and compares at the output.
module tb_scaler_v_linebuf;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int LMAX = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] di_i = '0;
  logic          de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [DW-1:0] do0_o, do1_o, do2_o, do3_o;
  logic          de_o, hs_o, vs_o, ovf_o;
  logic [1:0]    lines_o;

  scaler_v_linebuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do0_o(do0_o), .do1_o(do1_o), .do2_o(do2_o), .do3_o(do3_o),
    .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .lines_o(lines_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d0, d1, d2, d3;
    logic [1:0]    lines;
    logic          ovf;
    int            stamp;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  logic [DW-1:0] hist [3][LMAX];
  logic [DW-1:0] cur [LMAX];
  int m_col = 0, m_cnt = 0;
  bit m_has = 0, m_synced = 0, m_ovf = 0, m_hs_d = 0, m_vs_d = 0;

  task automatic model_reset();
    m_col = 0; m_cnt = 0; m_has = 0; m_synced = 0; m_ovf = 0; m_hs_d = 0; m_vs_d = 0;
  endtask

  task automatic drive(input bit de, input bit hs, input bit vs, input logic [DW-1:0] d);
    exp_t e;
    bit hr, vr;
    @(posedge clk);
    #1;
    de_i = de; hs_i = hs; vs_i = vs; di_i = d;
    hr = hs && !m_hs_d;
    vr = vs && !m_vs_d;
    if (de && !hs && !vs) begin
      e.d0 = d;
      e.lines = 2'(m_cnt);
      e.stamp = cyc + 2;
      if (m_col < LMAX) begin
        e.d1 = (m_cnt >= 1) ? hist[0][m_col] : '0;
        e.d2 = (m_cnt >= 2) ? hist[1][m_col] : '0;
        e.d3 = (m_cnt >= 3) ? hist[2][m_col] : '0;
        cur[m_col] = d;
        m_col++;
        m_has = 1;
      end else begin
        e.d1 = '0; e.d2 = '0; e.d3 = '0;
        m_ovf = 1;
      end
      e.ovf = m_ovf;
      exp_q.push_back(e);
    end
    if (vr) begin
      m_col = 0; m_cnt = 0; m_has = 0; m_ovf = 0; m_synced = 1;
    end else if (hr) begin
      if (m_has) begin
        for (int c = 0; c < LMAX; c++) begin
          hist[2][c] = hist[1][c];
          hist[1][c] = hist[0][c];
          hist[0][c] = cur[c];
        end
        if (m_synced && m_cnt < 3) m_cnt++;
      end
      m_col = 0;
      m_has = 0;
    end
    m_hs_d = hs;
    m_vs_d = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0);
  endtask

  task automatic vs_pulse();
    drive(0, 0, 1, '0);
    drive(0, 0, 0, '0);
  endtask

  task automatic hs_pulse();
    drive(0, 1, 0, '0);
    drive(0, 0, 0, '0);
  endtask

  task automatic line(input int n, input int base);
    for (int c = 0; c < n; c++) drive(1, 0, 0, DW'(base + c));
  endtask

  // monitor: every valid output pixel pops one expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && de_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pixel: de_o=1 do0=%0h with no pixel expected", do0_o);
      end else begin
        e = exp_q.pop_front();
        n_checks++; if (do0_o !== e.d0) $display("FAIL do0: got %0h expected %0h", do0_o, e.d0); else n_pass++;
        n_checks++; if (do1_o !== e.d1) $display("FAIL do1: got %0h expected %0h (do0=%0h)", do1_o, e.d1, e.d0); else n_pass++;
        n_checks++; if (do2_o !== e.d2) $display("FAIL do2: got %0h expected %0h (do0=%0h)", do2_o, e.d2, e.d0); else n_pass++;
        n_checks++; if (do3_o !== e.d3) $display("FAIL do3: got %0h expected %0h (do0=%0h)", do3_o, e.d3, e.d0); else n_pass++;
        n_checks++; if (lines_o !== e.lines) $display("FAIL lines: got %0d expected %0d (do0=%0h)", lines_o, e.lines, e.d0); else n_pass++;
        n_checks++; if (ovf_o !== e.ovf) $display("FAIL ovf: got %0b expected %0b (do0=%0h)", ovf_o, e.ovf, e.d0); else n_pass++;
        n_checks++; if (cyc !== e.stamp) $display("FAIL latency: output cycle %0d expected %0d", cyc, e.stamp); else n_pass++;
        $display("pixel do0=%0h do1=%0h do2=%0h do3=%0h lines=%0d ovf=%0b", do0_o, do1_o, do2_o, do3_o, lines_o, ovf_o);
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({de_o, hs_o, vs_o, ovf_o} !== 4'b0) $display("FAIL reset_ctrl: got %b expected 0000", {de_o, hs_o, vs_o, ovf_o}); else n_pass++;
    n_checks++; if (lines_o !== 2'd0) $display("FAIL reset_lines: got %0d expected 0", lines_o); else n_pass++;
    n_checks++; if ({do0_o, do1_o, do2_o, do3_o} !== '0) $display("FAIL reset_taps: got %0h expected 0", {do0_o, do1_o, do2_o, do3_o}); else n_pass++;
    rst = 1'b1;
    idle(2);
    $display("test_reset done");
  endtask

  task automatic test_four_lines();
    vs_pulse();
    for (int n = 0; n < 4; n++) begin
      hs_pulse();
      line(8, 16 * n);
    end
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL four_lines_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (do3_o !== 8'd7) $display("FAIL four_lines_hold: got do3=%0h expected 7", do3_o); else n_pass++;
  endtask

  task automatic test_first_lines();
    vs_pulse();
    line(4, 8'h60);
    hs_pulse();
    line(4, 8'h70);
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL first_lines_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_overflow();
    vs_pulse();
    hs_pulse();
    line(10, 8'hB0);
    hs_pulse();
    line(2, 8'hC0);
    idle(4);
    n_checks++; if (ovf_o !== 1'b1) $display("FAIL ovf_sticky: got %0b expected 1", ovf_o); else n_pass++;
    vs_pulse();
    hs_pulse();
    line(3, 8'hD0);
    idle(4);
    n_checks++; if (ovf_o !== 1'b0) $display("FAIL ovf_cleared: got %0b expected 0", ovf_o); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL overflow_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_double_hs();
    vs_pulse();
    hs_pulse();
    line(8, 8'h10);
    hs_pulse();
    idle(2);
    hs_pulse();
    line(8, 8'h20);
    hs_pulse();
    hs_pulse();
    line(8, 8'h30);
    idle(4);
    n_checks++; if (lines_o !== 2'd2) $display("FAIL double_hs_lines: got %0d expected 2", lines_o); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL double_hs_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_hs_vs_same();
    vs_pulse();
    for (int n = 0; n < 3; n++) begin
      hs_pulse();
      line(8, 8'h80 + 8 * n);
    end
    drive(0, 1, 1, '0);
    drive(0, 0, 0, '0);
    line(8, 8'h50);
    hs_pulse();
    line(8, 8'h58);
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL hs_vs_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    vs_pulse();
    for (int l = 0; l < 6; l++) begin
      drive(1, 1, 0, DW'($urandom_range(0, 255)));
      drive(0, 0, 0, '0);
      for (int c = 0; c < LMAX; c++) begin
        if ($urandom_range(0, 3) == 0) drive(0, 0, 0, DW'($urandom_range(0, 255)));
        drive(1, 0, 0, DW'($urandom_range(0, 255)));
      end
    end
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL back_to_back_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midline();
    vs_pulse();
    hs_pulse();
    line(8, 8'h40);
    hs_pulse();
    line(5, 8'h60);
    idle(3);
    n_checks++; if (exp_q.size() != 0) $display("FAIL pre_reset_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (lines_o !== 2'd0) $display("FAIL async_reset_lines: got %0d expected 0", lines_o); else n_pass++;
    n_checks++; if (do1_o !== '0) $display("FAIL async_reset_do1: got %0h expected 0", do1_o); else n_pass++;
    n_checks++; if ({do0_o, do2_o, do3_o, de_o, hs_o, vs_o, ovf_o} !== '0) $display("FAIL async_reset_rest: got %0h expected 0", {do0_o, do2_o, do3_o, de_o, hs_o, vs_o, ovf_o}); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    line(3, 8'h70);
    hs_pulse();
    line(4, 8'h78);
    vs_pulse();
    hs_pulse();
    line(4, 8'h90);
    hs_pulse();
    line(4, 8'hA0);
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL post_reset_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_four_lines();
    test_first_lines();
    test_overflow();
    test_double_hs();
    test_hs_vs_same();
    test_back_to_back();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scaler_v_linebuf.md
SCALER_V_LINEBUF -- requirements
Module: scaler_v_linebuf

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width.
REQ-002 Parameter ADDR_WIDTH, default 12: line-buffer address width; maximum line length LINE_MAX = 2^ADDR_WIDTH pixels.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 di_i  input  DATA_WIDTH  pixel from horizontal scaler (qualified by de_i).
REQ-006 de_i  input  1  pixel valid.
REQ-007 hs_i  input  1  line sync, active high.
REQ-008 vs_i  input  1  frame sync, active high.
REQ-009 do0_o  output  DATA_WIDTH  tap 0: current-line pixel (newest).
REQ-010 do1_o, do2_o, do3_o  output  DATA_WIDTH each  taps 1..3: same column, 1, 2 and 3 lines earlier.
REQ-011 de_o, hs_o, vs_o  output  1 each  de_i, hs_i, vs_i delayed to align with taps.
REQ-012 lines_o  output  2  previous lines held in this frame, saturating at 3, aligned with taps.
REQ-013 ovf_o  output  1  sticky: a line exceeded LINE_MAX pixels in this frame.

Function
REQ-014 Storage: 4 line banks of LINE_MAX x DATA_WIDTH, one simple dual-port RAM each; one bank is written, the other three are read.
REQ-015 State: wr_bank (2 bit, mod 4), wr_addr (ADDR_WIDTH+1 bit), line_has_pix (1 bit), line_cnt (2 bit, saturating), ovf (1 bit), registered hs_d/vs_d for edge detection.
REQ-016 Pixel accept: de_i=1 and hs_i=0 and vs_i=0; de_i while hs_i or vs_i is high is ignored (no write, de_o=0).
REQ-017 On accepted pixel with wr_addr<LINE_MAX: write di_i to bank wr_bank at wr_addr, read banks wr_bank-1, -2, -3 (mod 4) at wr_addr, increment wr_addr, set line_has_pix.
REQ-018 On accepted pixel with wr_addr=LINE_MAX: no write, set ovf; pixel still output with do1..do3 = 0.
REQ-019 Line advance on hs_i rising edge (hs_i=1, hs_d=0): wr_addr<=0; if line_has_pix then wr_bank<=wr_bank+1 and line_cnt<=min(line_cnt+1,3); clear line_has_pix. An empty line does not advance.
REQ-020 Frame start on vs_i rising edge: wr_bank<=0, wr_addr<=0, line_cnt<=0, line_has_pix<=0, ovf<=0; vs_i rise takes priority over a coincident hs_i rise.
REQ-021 Boundary taps: tap k (k=1..3) outputs 0 when k > line_cnt at the pixel's accept cycle.
REQ-022 Latency: exactly 2 clk from input cycle to outputs (cycle 1 RAM read, cycle 2 output register) for taps, de_o, hs_o, vs_o, lines_o, ovf_o; do0_o is di_i delayed 2 clk.
REQ-023 Taps hold last value when de_o=0; no new values without a valid pixel.
REQ-024 Read/write never target the same bank in one cycle; no read-during-write hazard is permitted.
REQ-025 A line shorter than its predecessor reads stale columns only up to its own length; longer lines read stale/uninitialised columns beyond predecessor length (defined as don't-care, not required to be zero).

Reset
REQ-026 rst=0 asynchronously clears all control state and all outputs to 0 (do*_o, de_o, hs_o, vs_o, lines_o, ovf_o); RAM contents are not cleared.
REQ-027 Release of rst (0->1) mid-frame: block waits for next vs_i rising edge before reporting lines_o>0; hs_d/vs_d reset to 0, so hs_i or vs_i already high at release counts as a rising edge.

Verification
REQ-028 vs pulse, then 4 lines of 8 pixels, line n pixel c = 16n+c -> on line 3 col 5: do0=53, do1=37, do2=21, do3=5, lines_o=3, each 2 clk after input.
REQ-029 vs pulse, first line of 4 pixels -> do1..do3=0, lines_o=0; second line -> do1=line-0 values, do2=do3=0, lines_o=1.
REQ-030 ADDR_WIDTH=3, line of 10 pixels -> pixels 9,10 output with do1..do3=0, ovf_o=1 until next vs; next frame ovf_o=0.
REQ-031 Two hs pulses with no de between -> wr_bank and lines_o advance once only.
REQ-032 hs_i and vs_i rise same cycle mid-frame -> lines_o=0 on next pixel, bank 0 written.
REQ-033 rst=0 for 1 clk mid-line -> all outputs 0 immediately (asynchronously, without waiting for a clk edge); after release, pixels before next vs give lines_o=0 and do1..do3=0.
